sccb_init_sequencer: RTL and testbench

SCCB_INIT_SEQUENCER -- requirements
Module: sccb_init_sequencer

---
 rtl/sccb_init_sequencer_if.sv | 19 +
 rtl/sccb_init_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_sccb_init_sequencer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sccb_init_sequencer_if.sv
// Byte-engine link between the init sequencer and the SCCB byte engine.
// The master side offers bytes; the slave side reports idle and ack pulses.
interface sccb_init_sequencer_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_stop;
  logic       tx_ready;
  logic       ack;

  modport master (
    output tx_data, tx_start, tx_stop,
    input  tx_ready, ack
  );

  modport slave (
    input  tx_data, tx_start, tx_stop,
    output tx_ready, ack
  );
endinterface

// File: rtl/sccb_init_sequencer.sv
// Walks a camera register table and issues one 4-byte SCCB write per entry.
// Table markers: 0xFFFF ends the run, 0xFFFE waits reg_data milliseconds.
module sccb_init_sequencer #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter logic [7:0]  SLAVE_ID = 8'h78,
  parameter int unsigned ADDR_W   = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [23:0]       i_rom_data,
  sccb_init_sequencer_if.master tx,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [ADDR_W-1:0] o_entry_cnt
);

  localparam int unsigned TICKS =
    (CLK_FREQ / 1000 > 0) ? CLK_FREQ / 1000 : 1;
  localparam int unsigned TW =
    (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    START_TX,
    SEND,
    WAIT_READY,
    DELAY,
    FINISH
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [23:0]       entry_q, entry_d;
  logic [7:0]        ms_q, ms_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic              low_q, low_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              adv;
  logic              tx_start;
  logic              is_end;
  logic              is_dly;
  logic [7:0]        tx_byte;

  assign is_end = (i_rom_data[23:8] == 16'hFFFF);
  assign is_dly = (i_rom_data[23:8] == 16'hFFFE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      bidx_q  <= '0;
      entry_q <= '0;
      ms_q    <= '0;
      tick_q  <= '0;
      low_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      bidx_q  <= bidx_d;
      entry_q <= entry_d;
      ms_q    <= ms_d;
      tick_q  <= tick_d;
      low_q   <= low_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    bidx_d   = bidx_q;
    entry_d  = entry_q;
    ms_d     = ms_q;
    tick_d   = tick_q;
    low_d    = low_q;
    busy_d   = busy_q;
    done_d   = done_q;
    err_d    = err_q;
    adv      = 1'b0;
    tx_start = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = FETCH;
          idx_d   = '0;
          cnt_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      FETCH: state_d = DECODE;
      DECODE: begin
        entry_d = i_rom_data;
        bidx_d  = 2'd0;
        unique case (1'b1)
          is_end: state_d = FINISH;
          is_dly: begin
            state_d = DELAY;
            ms_d    = i_rom_data[7:0];
            tick_d  = '0;
          end
          default: state_d = START_TX;
        endcase
      end
      START_TX: begin
        if (tx.tx_ready) begin
          tx_start = 1'b1;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (tx.ack) begin
          if (bidx_q == 2'd3) begin
            state_d = WAIT_READY;
            cnt_d   = cnt_q + 1'b1;
            low_d   = 1'b0;
          end else begin
            bidx_d = bidx_q + 2'd1;
          end
        end
      end
      WAIT_READY: begin
        // The engine must visibly go busy before idle counts as finished.
        if (!tx.tx_ready) begin
          low_d = 1'b1;
        end else if (low_q) begin
          adv = 1'b1;
        end
      end
      DELAY: begin
        if (ms_q == 8'd0) begin
          adv = 1'b1;
        end else if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (ms_q == 8'd1) begin
            adv = 1'b1;
          end else begin
            ms_d = ms_q - 8'd1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      FINISH: begin
        done_d  = !err_q;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Running off the top of the table is an error, never a wrap.
    if (adv) begin
      if (&idx_q) begin
        err_d   = 1'b1;
        state_d = FINISH;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = FETCH;
      end
    end
  end

  always_comb begin
    tx_byte = SLAVE_ID;
    unique case (bidx_q)
      2'd0: tx_byte = SLAVE_ID;
      2'd1: tx_byte = entry_q[23:16];
      2'd2: tx_byte = entry_q[15:8];
      2'd3: tx_byte = entry_q[7:0];
      default: tx_byte = SLAVE_ID;
    endcase
  end

  assign tx.tx_data  = tx_byte;
  assign tx.tx_start = tx_start;
  assign tx.tx_stop  = (state_q == SEND) && (bidx_q == 2'd3);

  assign o_rom_addr  = idx_q;
  assign o_entry_cnt = cnt_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Bench for sccb_init_sequencer: ROM model, byte-engine model, byte scoreboard.
// Small table (ADDR_W=2) and 1 MHz clock so delays and overrun are reachable.
module tb_sccb_init_sequencer;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [AW-1:0] entry_cnt;
  logic [23:0]   rom_q;
  logic [23:0]   rom [4];
  logic          busy, done, err;
  logic          eng_ready = 1'b1;
  logic          eng_ack = 1'b0;
  logic          stall = 1'b0;
  logic          prev_start = 1'b0;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int consec = 0;
  int stall_starts = 0;
  int byte_cnt = 0;
  int eph = 0;
  int t = 0;
  int nb = 0;

  logic [8:0] exp_q [$];

  sccb_init_sequencer_if tx();

  assign tx.tx_ready = eng_ready & ~stall;
  assign tx.ack      = eng_ack;

  sccb_init_sequencer #(
    .CLK_FREQ(1_000_000),
    .SLAVE_ID(8'h78),
    .ADDR_W(AW)
  ) u_dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_start(start),
    .o_rom_addr(rom_addr),
    .i_rom_data(rom_q),
    .tx(tx),
    .o_busy(busy),
    .o_done(done),
    .o_err(err),
    .o_entry_cnt(entry_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_q <= rom[rom_addr];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic score(input logic [7:0] d, input logic s);
    logic [8:0] e;
    byte_cnt++;
    if (exp_q.size() == 0) begin
      chk("extra_byte", exp_q.size(), 1);
    end else begin
      e = exp_q.pop_front();
      chk("byte", {24'd0, d}, {24'd0, e[7:0]});
      chk("stop", {31'd0, s}, {31'd0, e[8]});
    end
  endtask

  // Engine: 3 cycles per byte, ack pulse per byte, idle 3 cycles after stop.
  always @(negedge clk) begin
    if (rst) begin
      eph = 0; t = 0; nb = 0;
      eng_ready = 1'b1; eng_ack = 1'b0; prev_start = 1'b0;
    end else begin
      if (tx.tx_start && prev_start) consec++;
      if (tx.tx_start && stall) stall_starts++;
      prev_start = tx.tx_start;
      eng_ack = 1'b0;
      case (eph)
        0: if (tx.tx_start && tx.tx_ready) begin
          start_cnt++; eph = 1; t = 0; nb = 0;
        end
        1: begin
          eng_ready = 1'b0;
          t++;
          if (t == 3) begin
            t = 0; nb++;
            score(tx.tx_data, tx.tx_stop);
            eng_ack = 1'b1;
            if (tx.tx_stop || nb == 8) eph = 2;
          end
        end
        default: begin
          t++;
          if (t == 3) begin
            eng_ready = 1'b1; eph = 0; t = 0;
          end
        end
      endcase
    end
  end

  task automatic push_write(input logic [15:0] a, input logic [7:0] d);
    exp_q.push_back({1'b0, 8'h78});
    exp_q.push_back({1'b0, a[15:8]});
    exp_q.push_back({1'b0, a[7:0]});
    exp_q.push_back({1'b1, d});
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_idle(input int mid, output int bcyc);
    int n;
    bit seen;
    n = 0; bcyc = 0; seen = 1'b0;
    while (n < 20000) begin
      if (busy) begin
        bcyc++; seen = 1'b1;
      end else if (seen) begin
        break;
      end
      start = (mid > 0) && (bcyc == mid);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (n >= 20000) chk("timeout", n, 0);
  endtask

  task automatic chk_reset_vals(input string p);
    chk({p, "_tx_start"}, {31'd0, tx.tx_start}, 0);
    chk({p, "_tx_stop"}, {31'd0, tx.tx_stop}, 0);
    chk({p, "_busy"}, {31'd0, busy}, 0);
    chk({p, "_done"}, {31'd0, done}, 0);
    chk({p, "_err"}, {31'd0, err}, 0);
    chk({p, "_cnt"}, {30'd0, entry_cnt}, 0);
    chk({p, "_rom_addr"}, {30'd0, rom_addr}, 0);
    chk({p, "_tx_data"}, {24'd0, tx.tx_data}, 32'h78);
  endtask

  initial begin
    int bc;
    int s0;
    int b0;
    int n;

    for (int i = 0; i < 4; i++) rom[i] = 24'hFFFF00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("rst");

    // Single write then end marker
    rom[0] = 24'h300880; rom[1] = 24'hFFFF00;
    push_write(16'h3008, 8'h80);
    s0 = start_cnt;
    pulse_start();
    wait_idle(0, bc);
    chk("w1_done", {31'd0, done}, 1);
    chk("w1_err", {31'd0, err}, 0);
    chk("w1_cnt", {30'd0, entry_cnt}, 1);
    chk("w1_starts", start_cnt - s0, 1);
    chk("w1_q", exp_q.size(), 0);

    // Start pulsed again mid-run is ignored
    push_write(16'h3008, 8'h80);
    s0 = start_cnt;
    pulse_start();
    wait_idle(10, bc);
    chk("mid_done", {31'd0, done}, 1);
    chk("mid_cnt", {30'd0, entry_cnt}, 1);
    chk("mid_starts", start_cnt - s0, 1);
    chk("mid_q", exp_q.size(), 0);

    // 2 ms delay: FETCH+DECODE+2000 DELAY+FETCH+DECODE+FINISH
    rom[0] = 24'hFFFE02; rom[1] = 24'hFFFF00;
    s0 = start_cnt;
    pulse_start();
    wait_idle(0, bc);
    chk("dly2_busy_cyc", bc, 2005);
    chk("dly2_starts", start_cnt - s0, 0);
    chk("dly2_done", {31'd0, done}, 1);

    // Zero delay passes straight through
    rom[0] = 24'hFFFE00;
    pulse_start();
    wait_idle(0, bc);
    chk("dly0_busy_cyc", bc, 6);
    chk("dly0_done", {31'd0, done}, 1);

    // Engine not ready while waiting in START_TX
    rom[0] = 24'h123456; rom[1] = 24'hFFFF00;
    push_write(16'h1234, 8'h56);
    s0 = start_cnt;
    stall_starts = 0;
    stall = 1'b1;
    pulse_start();
    repeat (52) @(posedge clk);
    chk("stall_no_start", start_cnt - s0, 0);
    #1 stall = 1'b0;
    #1 chk("start_on_ready", {31'd0, tx.tx_start}, 1);
    chk("stall_starts", stall_starts, 0);
    wait_idle(0, bc);
    chk("stall_done", {31'd0, done}, 1);
    chk("stall_starts_total", start_cnt - s0, 1);
    chk("stall_q", exp_q.size(), 0);

    // No end marker: four writes then overrun error
    rom[0] = 24'h000111; rom[1] = 24'h000222;
    rom[2] = 24'h000333; rom[3] = 24'h000444;
    push_write(16'h0001, 8'h11);
    push_write(16'h0002, 8'h22);
    push_write(16'h0003, 8'h33);
    push_write(16'h0004, 8'h44);
    s0 = start_cnt;
    pulse_start();
    wait_idle(0, bc);
    chk("ovr_err", {31'd0, err}, 1);
    chk("ovr_done", {31'd0, done}, 0);
    chk("ovr_busy", {31'd0, busy}, 0);
    chk("ovr_starts", start_cnt - s0, 4);
    chk("ovr_q", exp_q.size(), 0);

    // Reset right after the second ack of a write
    rom[0] = 24'h1111AA; rom[1] = 24'h2222BB; rom[2] = 24'hFFFF00;
    push_write(16'h1111, 8'hAA);
    push_write(16'h2222, 8'hBB);
    b0 = byte_cnt;
    pulse_start();
    n = 0;
    while (byte_cnt < b0 + 2 && n < 500) begin
      @(posedge clk); n++;
    end
    chk("mrst_reach", n < 500, 1);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset_vals("mrst");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    s0 = start_cnt;
    repeat (20) @(negedge clk);
    chk("mrst_quiet", start_cnt - s0, 0);
    chk("mrst_idle", {31'd0, busy}, 0);
    push_write(16'h1111, 8'hAA);
    push_write(16'h2222, 8'hBB);
    pulse_start();
    wait_idle(0, bc);
    chk("rerun_done", {31'd0, done}, 1);
    chk("rerun_cnt", {30'd0, entry_cnt}, 2);
    chk("rerun_starts", start_cnt - s0, 2);
    chk("rerun_q", exp_q.size(), 0);

    chk("consec_start", consec, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
